uart_baud_gen: RTL
==================

# uart_baud_gen

Programmable fractional baud-rate generator, successor to the fixed-divisor UART tick counter. It derives an oversample tick from the system clock using an integer-plus-fractional divisor that can be changed at run time. It also derives a mid-bit sample tick and an end-of-bit tick. It sits between the clock domain and both UART TX and RX; RX uses `resync` to align bit phase to a start-bit edge.

## Interface
- `DIV_W`, 16: width of integer divisor part.
- `FRAC_W`, 4: width of fractional divisor part (units of 1/2^FRAC_W clock).
- `OVERSAMPLE`, 16: oversample ticks per bit; power of two, ≥4.
- `DEFAULT_INT`, 107: integer divisor after reset.
- `DEFAULT_FRAC`, 7: fractional divisor after reset (107.4375 ≈ 16.5 MHz / 153600).

Ports:
- `clk` in 1: system clock; single clock domain.
- `reset` in 1: asynchronous, active-low reset.
- `enable` in 1: run request; low holds generator idle.
- `div_int` in DIV_W: new integer divisor.
- `div_frac` in FRAC_W: new fractional divisor.
- `div_load` in 1: one-cycle strobe capturing `div_int`/`div_frac` into shadow.
- `resync` in 1: one-cycle strobe restarting bit phase.
- `div_pending` out 1: shadow captured but not yet active.
- `os_tick` out 1: oversample tick, one-cycle pulse.
- `mid_tick` out 1: mid-bit sample pulse.
- `bit_tick` out 1: end-of-bit pulse.
- `os_phase` out clog2(OVERSAMPLE): current oversample index within bit.

## Operation
- State:
  - `en_q`: registered `enable`.
  - `cnt`: DIV_W+1 bits.
  - `acc`: FRAC_W bits.
  - `carry`: 1 bit.
  - `os_cnt`
  - Active divisor `act_int`/`act_frac`.
  - Shadow divisor plus pending flag.
- Effective integer `I = max(act_int, 2)`. Values 0 and 1 clamp to 2.
- Current period `P = I + carry` clocks.
- Clock counting:
  - While `en_q`=1, `cnt` increments each clock.
  - `os_tick` = `en_q` && `cnt` == P−1.
  - On `os_tick`: `cnt`←0, `{carry,acc}`←`acc`+`act_frac`, `os_cnt`←`os_cnt`+1 (wraps at OVERSAMPLE).
- Long-run mean period = `act_int` + `act_frac`/2^FRAC_W. No period differs from I by more than one clock.
- Oversample decodes:
  - `mid_tick` = `os_tick` && `os_cnt` == OVERSAMPLE/2−1.
  - `bit_tick` = `os_tick` && `os_cnt` == OVERSAMPLE−1.
  - `os_phase` = `os_cnt`.
- Idle: while `en_q`=0, `cnt`, `acc`, `carry`, `os_cnt` are held at 0 and no ticks occur.
- `resync` with `en_q`=1 clears `cnt`, `acc`, `carry`, `os_cnt` on the next edge.
- Divisor update:
  - `div_load` writes shadow and sets `div_pending`.
  - The update is applied on a boundary edge: `os_tick`, `en_q`=0, or `resync`.
  - At that edge, active←(`div_load` ? inputs : shadow) and `div_pending` clears.
- Simultaneous events:
  - `div_load` + boundary in the same cycle: the input value applies immediately, and `div_pending` stays 0.
  - Second `div_load` while pending: overwrites shadow.
  - `resync` + `os_tick` in the same cycle: `resync` wins and `os_cnt`←0.
  - `resync` while idle: no effect.

## Timing
- Reset (async assert): all counters 0, `en_q`=0, active = DEFAULT_INT/DEFAULT_FRAC, shadow = defaults, `div_pending`=0.
- Outputs during reset: all outputs 0 immediately.
- All outputs are decodes of registers only. There is no combinational input→output path.
- `enable`, `resync` and `div_load` take effect on the edge at which they are sampled.
- After `en_q` rises (or after `resync`), the first `os_tick` occurs I cycles later, since `carry`=0.
- Deasserting `enable` mid-bit: ticks stop from the cycle after `en_q` falls; phase is lost.
- Divisor changes never shorten a period in progress. The new value governs the period starting after the boundary.

## Structure
- Shared package `uart_pkg`:
  - OVERSAMPLE default.
  - DEFAULT_INT/DEFAULT_FRAC.
  - Minimum-divisor constant 2.
  - clog2-derived phase width.
- Natural sub-module `uart_frac_divider`: `cnt`/`acc`/`carry` and the `os_tick` decode, with divisor and clear inputs.
- Top level holds: `en_q`, shadow/pending logic, `os_cnt`, `mid_tick`/`bit_tick` decode.

## Test plan
- Defaults, `enable`=1 from reset release:
  - first `os_tick` 107 cycles after `en_q` rises;
  - first `bit_tick` 1718 cycles after `en_q`;
  - every later `bit_tick` spacing exactly 1719;
  - `os_tick` spacings only 107 or 108.
- Load `div_int`=4, `div_frac`=0, then `resync`: `os_tick` every 4 cycles, `mid_tick` at 32 and `bit_tick` at 64 cycles after `resync`, `os_phase` cycles 0..15.
- Load 8.0 mid-period at divisor 4.0:
  - `div_pending`=1 until the next `os_tick`, then 0;
  - that period is still 4; following periods are 8.
- `div_int`=1 and `div_int`=0: `os_tick` every 2 cycles.
- `resync` asserted at `os_phase`=9: `os_phase` returns to 0; next `os_tick` I cycles later; `bit_tick` 16 ticks later.
- `reset` asserted mid-bit after a load of 4.0:
  - all outputs 0 asynchronously;
  - after release, behaviour matches the defaults scenario (107.4375).

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants for the UART baud generator and its fractional divider.
// Reset divisor 107.4375 gives 16x oversampling at 9600 baud from a 16.5 MHz clock.
package uart_pkg;
  localparam int UART_OVERSAMPLE   = 16;
  localparam int UART_DEFAULT_INT  = 107;
  localparam int UART_DEFAULT_FRAC = 7;
  localparam int UART_MIN_DIV      = 2;
  localparam int UART_PHASE_W      = $clog2(UART_OVERSAMPLE);
endpackage

// File: rtl/uart_frac_divider.sv
// Integer+fractional clock divider: one os_tick per I or I+1 clocks, decoded from registers only.
// Latency: first tick I clocks after run rises or clr. Backpressure: none, free-running.
module uart_frac_divider
  import uart_pkg::*;
#(
  parameter int DIV_W  = 16,
  parameter int FRAC_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              clr,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  output logic              os_tick
);

  logic [DIV_W:0]    cnt_q, cnt_d;
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic              carry_q, carry_d;
  logic [DIV_W:0]    i_eff;
  logic [DIV_W:0]    period;
  logic [FRAC_W:0]   acc_sum;

  always_comb begin
    // Divisors 0 and 1 clamp to 2 so a tick never lands on consecutive clocks.
    i_eff   = (div_int < DIV_W'(UART_MIN_DIV)) ? (DIV_W+1)'(UART_MIN_DIV) : {1'b0, div_int};
    period  = i_eff + {{DIV_W{1'b0}}, carry_q};
    os_tick = run && (cnt_q == period - (DIV_W+1)'(1));
    acc_sum = {1'b0, acc_q} + {1'b0, div_frac};

    cnt_d   = cnt_q + (DIV_W+1)'(1);
    acc_d   = acc_q;
    carry_d = carry_q;
    if (!run || clr) begin
      cnt_d   = '0;
      acc_d   = '0;
      carry_d = 1'b0;
    end else if (os_tick) begin
      cnt_d            = '0;
      {carry_d, acc_d} = acc_sum;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
    end
  end

endmodule

// File: rtl/uart_baud_gen.sv
// Programmable fractional baud generator: oversample, mid-bit and end-of-bit ticks, resyncable phase.
// Latency: first os_tick I clocks after enable/resync is sampled. Backpressure: none.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int DIV_W        = 16,
  parameter int FRAC_W       = 4,
  parameter int OVERSAMPLE   = UART_OVERSAMPLE,
  parameter int DEFAULT_INT  = UART_DEFAULT_INT,
  parameter int DEFAULT_FRAC = UART_DEFAULT_FRAC,
  localparam int PH_W        = $clog2(OVERSAMPLE)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  input  logic              div_load,
  input  logic              resync,
  output logic              div_pending,
  output logic              os_tick,
  output logic              mid_tick,
  output logic              bit_tick,
  output logic [PH_W-1:0]   os_phase
);

  logic              en_q, en_d;
  logic [DIV_W-1:0]  act_int_q, act_int_d;
  logic [FRAC_W-1:0] act_frac_q, act_frac_d;
  logic [DIV_W-1:0]  shd_int_q, shd_int_d;
  logic [FRAC_W-1:0] shd_frac_q, shd_frac_d;
  logic              pend_q, pend_d;
  logic [PH_W-1:0]   os_cnt_q, os_cnt_d;
  logic              tick_w;
  logic              boundary;

  uart_frac_divider #(
    .DIV_W  (DIV_W),
    .FRAC_W (FRAC_W)
  ) u_div (
    .clk      (clk),
    .reset    (reset),
    .run      (en_q),
    .clr      (resync),
    .div_int  (act_int_q),
    .div_frac (act_frac_q),
    .os_tick  (tick_w)
  );

  always_comb begin
    en_d       = enable;
    // A new divisor only takes over where a period starts, so no period in flight is cut short.
    boundary   = tick_w || !en_q || resync;
    shd_int_d  = div_load ? div_int  : shd_int_q;
    shd_frac_d = div_load ? div_frac : shd_frac_q;
    act_int_d  = act_int_q;
    act_frac_d = act_frac_q;
    if (boundary) begin
      act_int_d  = div_load ? div_int  : shd_int_q;
      act_frac_d = div_load ? div_frac : shd_frac_q;
    end
    pend_d = boundary ? 1'b0 : (div_load || pend_q);

    os_cnt_d = os_cnt_q;
    if (!en_q || resync) begin
      os_cnt_d = '0;
    end else if (tick_w) begin
      os_cnt_d = os_cnt_q + PH_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en_q       <= 1'b0;
      act_int_q  <= DIV_W'(DEFAULT_INT);
      act_frac_q <= FRAC_W'(DEFAULT_FRAC);
      shd_int_q  <= DIV_W'(DEFAULT_INT);
      shd_frac_q <= FRAC_W'(DEFAULT_FRAC);
      pend_q     <= 1'b0;
      os_cnt_q   <= '0;
    end else begin
      en_q       <= en_d;
      act_int_q  <= act_int_d;
      act_frac_q <= act_frac_d;
      shd_int_q  <= shd_int_d;
      shd_frac_q <= shd_frac_d;
      pend_q     <= pend_d;
      os_cnt_q   <= os_cnt_d;
    end
  end

  assign os_tick     = tick_w;
  assign mid_tick    = tick_w && (os_cnt_q == PH_W'(OVERSAMPLE/2 - 1));
  assign bit_tick    = tick_w && (os_cnt_q == PH_W'(OVERSAMPLE - 1));
  assign div_pending = pend_q;
  assign os_phase    = os_cnt_q;

endmodule
